// File: rtl/rgbled_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rgbled_pkg
//  Description : Shared constants and FSM state type for the RGB LED frame
//                arbiter. The pixel geometry defaults here seed the top-level
//                parameters.
//  Revision    : 1.0 - initial release
// ============================================================================
package rgbled_pkg;

  // Pixel chain geometry (GRB, 8 bits per colour).
  localparam int NUM_LEDS     = 3;
  localparam int BITS_PER_LED = 24;
  localparam int DATA_W       = NUM_LEDS * BITS_PER_LED;

  // Frame FSM: one strobe cycle, then a hold window that covers the
  // driver's shift time plus latch gap.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STROBE = 2'd1,
    HOLD   = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/rgbled_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rgbled_rr_arbiter
//  Description : Two-way round-robin decision, purely combinational.
//                A lone request wins outright; on a tie the requester that
//                was not granted last wins. winner is meaningless when
//                neither request is set.
//  Ports       : req[1:0] - pending requests {req1, req0}
//                last     - index of the most recently granted requester
//                winner   - index of the requester to serve next
//  Revision    : 1.0 - initial release
// ============================================================================
module rgbled_rr_arbiter (
  input  logic [1:0] req,
  input  logic       last,
  output logic       winner
);

  import rgbled_pkg::*;

  always_comb begin
    winner = 1'b0;
    case (req)
      2'b10:   winner = 1'b1;
      2'b11:   winner = ~last;
      default: winner = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/rgbled_frame_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rgbled_frame_arbiter
//  Description : Arbitrates two frame requesters onto one RGB LED driver.
//                On acceptance the winning frame is registered together with
//                its grant index, a one-cycle ack and a one-cycle data_rdy
//                strobe; the block then holds off for the driver's frame
//                time before it will accept again.
//  Ports       : clk          - rising-edge clock
//                nreset       - synchronous active-low reset
//                req0/req1    - requester has a frame pending
//                data0/data1  - requester frame, stable while req is high
//                ack0/ack1    - one-cycle acceptance pulse per requester
//                data         - frame presented to the LED driver
//                data_rdy     - one-cycle strobe to the LED driver
//                grant        - index of the requester owning data
//                busy         - high whenever the FSM is not idle
//  Revision    : 1.0 - initial release
// ============================================================================
module rgbled_frame_arbiter #(
  parameter  int NUM_LEDS     = rgbled_pkg::NUM_LEDS,
  parameter  int BITS_PER_LED = rgbled_pkg::BITS_PER_LED,
  parameter  int FRAME_CYCLES = 8000,
  localparam int DATA_W       = NUM_LEDS * BITS_PER_LED
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              req0,
  input  logic [DATA_W-1:0] data0,
  output logic              ack0,
  input  logic              req1,
  input  logic [DATA_W-1:0] data1,
  output logic              ack1,
  output logic [DATA_W-1:0] data,
  output logic              data_rdy,
  output logic              grant,
  output logic              busy
);

  import rgbled_pkg::*;

  localparam int CNT_W = $clog2(FRAME_CYCLES);

  state_t            state;
  state_t            state_next;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_next;
  logic              last;
  logic              last_next;
  logic              winner;
  logic              accept;

  logic [DATA_W-1:0] data_next;
  logic              grant_next;
  logic              ack0_next;
  logic              ack1_next;
  logic              data_rdy_next;
  logic              busy_next;

  rgbled_rr_arbiter u_rr (
    .req    ({req1, req0}),
    .last   (last),
    .winner (winner)
  );

  // A frame is taken only from IDLE; requests seen in STROBE/HOLD simply
  // stay pending because requesters keep req high until acked.
  assign accept = (state == IDLE) && (req0 || req1);

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      state    <= IDLE;
      cnt      <= '0;
      last     <= 1'b1;
      data     <= '0;
      grant    <= 1'b0;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      data_rdy <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      last     <= last_next;
      data     <= data_next;
      grant    <= grant_next;
      ack0     <= ack0_next;
      ack1     <= ack1_next;
      data_rdy <= data_rdy_next;
      busy     <= busy_next;
    end
  end

  // Next state. HOLD is loaded with FRAME_CYCLES-2 so that STROBE + HOLD +
  // the IDLE evaluation cycle span FRAME_CYCLES+1 cycles strobe to strobe.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (accept) state_next = STROBE;
      end
      STROBE: begin
        state_next = HOLD;
        cnt_next   = CNT_W'(FRAME_CYCLES - 2);
      end
      HOLD: begin
        if (cnt == '0) state_next = IDLE;
        else           cnt_next   = cnt - CNT_W'(1);
      end
      default: state_next = IDLE;
    endcase
  end

  // Next output values. ack/data_rdy default low so they are single-cycle
  // pulses; data, grant and last hold until the next acceptance.
  always_comb begin
    data_next     = data;
    grant_next    = grant;
    last_next     = last;
    ack0_next     = 1'b0;
    ack1_next     = 1'b0;
    data_rdy_next = 1'b0;
    busy_next     = (state_next != IDLE);
    if (accept) begin
      data_next     = winner ? data1 : data0;
      grant_next    = winner;
      last_next     = winner;
      ack0_next     = ~winner;
      ack1_next     = winner;
      data_rdy_next = 1'b1;
    end
  end

endmodule
`default_nettype wire
